nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_pkg.sv | 31 +++
 rtl/nibble_serial_adder_if.sv | 48 ++++
 rtl/nibble_serial_adder_rca_4b.sv | 34 +++
 rtl/nibble_serial_adder.sv | 131 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_pkg
// Shared definitions for the nibble-serial adder:
//   state_t    - controller states (IDLE, RUN, DONE)
//   NIB_W      - width of one nibble pass through the shared 4-bit adder
//   cnt_width  - width of a counter able to index NIB nibble passes
// ---------------------------------------------------------------------------
package nibble_serial_adder_pkg;

   // Bits handled by one pass through the shared ripple-carry adder.
   localparam int NIB_W = 4;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A counter for a single pass still needs one bit, so the result
   // never collapses to a zero-width vector when WIDTH equals NIB_W.
   function automatic int cnt_width(input int passes);
      int w;
      w = 1;
      while ((1 << w) < passes) begin
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_if
// Request/result bundle for the nibble-serial adder.
//   start  - request a new addition (sampled only when the adder is not busy)
//   a, b   - WIDTH-bit operands, captured on the accepted start
//   cin    - carry-in, captured on the accepted start
//   busy   - high while nibble passes are in progress
//   done   - one-cycle completion pulse
//   sum    - WIDTH-bit result
//   cout   - carry-out of the full WIDTH-bit addition
// Modports: master drives the request and reads results; slave is the adder.
// ---------------------------------------------------------------------------
interface nibble_serial_adder_if #(
   parameter int WIDTH = 16
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start,
      output a,
      output b,
      output cin,
      input  busy,
      input  done,
      input  sum,
      input  cout
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      input  cin,
      output busy,
      output done,
      output sum,
      output cout
   );

endinterface

// File: rtl/nibble_serial_adder_rca_4b.sv
// ---------------------------------------------------------------------------
// rca_4b
// Purely combinational 4-bit ripple-carry adder; the only adder in the
// nibble-serial datapath, shared across all nibble passes.
//   a, b  - 4-bit addends
//   cin   - carry into bit 0
//   sum   - 4-bit sum
//   cout  - carry out of bit 3
// ---------------------------------------------------------------------------
module rca_4b
   import nibble_serial_adder_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] sum,
   output logic             cout
);

   logic [NIB_W:0] carry;

   // Chain of full adders; carry[i] is the carry into bit i.
   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int i = 0; i < NIB_W; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      cout = carry[NIB_W];
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
// WIDTH-bit adder that processes one nibble per clock, LSB first, through a
// single time-shared rca_4b. A start in IDLE (or in the DONE cycle) captures
// the operands; busy is high for NIB cycles, then done pulses for one cycle
// with sum/cout valid. sum/cout hold until the first pass of the next
// operation overwrites them.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (takes priority over start)
//   bus  - nibble_serial_adder_if slave modport (start/a/b/cin in,
//          busy/done/sum/cout out)
// WIDTH must be a multiple of 4 and at least 4.
// ---------------------------------------------------------------------------
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   nibble_serial_adder_if.slave  bus
);

   localparam int NIB   = WIDTH / NIB_W;
   localparam int CNT_W = cnt_width(NIB);

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry_reg;
   logic             cout_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [CNT_W-1:0] pass_cnt;

   logic [NIB_W-1:0] nib_a;
   logic [NIB_W-1:0] nib_b;
   logic [NIB_W-1:0] nib_sum;
   logic             nib_cout;
   logic             last_pass;

   // Select nibble k of each captured operand for the current pass.
   always_comb begin
      nib_a     = a_reg[int'(pass_cnt) * NIB_W +: NIB_W];
      nib_b     = b_reg[int'(pass_cnt) * NIB_W +: NIB_W];
      last_pass = (pass_cnt == CNT_W'(NIB - 1));
   end

   rca_4b u_rca (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_reg),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

   // Controller and datapath registers. busy and done are registered so
   // start never reaches them combinationally. sum_reg is not touched on an
   // accepted start, which keeps the previous result visible through the
   // first RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         pass_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  a_reg     <= bus.a;
                  b_reg     <= bus.b;
                  carry_reg <= bus.cin;
                  pass_cnt  <= '0;
                  busy_reg  <= 1'b1;
                  state     <= RUN;
               end
            end

            RUN: begin
               sum_reg[int'(pass_cnt) * NIB_W +: NIB_W] <= nib_sum;
               carry_reg <= nib_cout;
               if (last_pass) begin
                  cout_reg <= nib_cout;
                  busy_reg <= 1'b0;
                  done_reg <= 1'b1;
                  pass_cnt <= '0;
                  state    <= DONE;
               end else begin
                  pass_cnt <= pass_cnt + CNT_W'(1);
               end
            end

            DONE: begin
               done_reg <= 1'b0;
               // A start here is taken immediately so operations can be
               // issued back to back without an IDLE cycle in between.
               if (bus.start) begin
                  a_reg     <= bus.a;
                  b_reg     <= bus.b;
                  carry_reg <= bus.cin;
                  pass_cnt  <= '0;
                  busy_reg  <= 1'b1;
                  state     <= RUN;
               end else begin
                  state <= IDLE;
               end
            end

            default: begin
               busy_reg <= 1'b0;
               done_reg <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_reg;
   assign bus.done = done_reg;
   assign bus.sum  = sum_reg;
   assign bus.cout = cout_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder
// Self-checking bench for nibble_serial_adder (WIDTH=16). Expected results
// are pushed to a queue when a start is driven and popped when done pulses.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder;
   import nibble_serial_adder_pkg::*;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / NIB_W;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
   } result_t;

   logic clk;
   logic rst;

   nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   result_t expected_q[$];
   int      n_checks = 0;
   int      n_fail   = 0;

   // Reference arithmetic: plain WIDTH+1 bit addition.
   function automatic result_t model_add(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic             cin);
      logic [WIDTH:0] t;
      result_t        r;
      t      = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);
      r.sum  = t[WIDTH-1:0];
      r.cout = t[WIDTH];
      return r;
   endfunction

   // Drive an accepted-start request and record what it must produce.
   task automatic drive_start(input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b,
                              input logic             cin);
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
      bus.start = 1'b1;
      expected_q.push_back(model_add(a, b, cin));
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.a     = 16'h1111;
      bus.b     = 16'h2222;
      bus.cin   = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_busy: got %b want 0", bus.busy);
      end
      n_checks++;
      if (bus.done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_done: got %b want 0", bus.done);
      end
      n_checks++;
      if (bus.sum !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL reset_sum: got %h want 0000", bus.sum);
      end
      n_checks++;
      if (bus.cout !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_cout: got %b want 0", bus.cout);
      end
      rst       = 1'b0;
      bus.start = 1'b0;
   endtask

   task automatic test_latency_zero();
      result_t exp;
      @(negedge clk);
      drive_start(16'h0000, 16'h0000, 1'b0);
      for (int c = 1; c <= NIB + 1; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         n_checks++;
         if (bus.busy !== ((c <= NIB) ? 1'b1 : 1'b0)) begin
            n_fail++;
            $display("[TB] FAIL latency_busy_c%0d: got %b want %b", c, bus.busy, (c <= NIB));
         end
         n_checks++;
         if (bus.done !== ((c == NIB + 1) ? 1'b1 : 1'b0)) begin
            n_fail++;
            $display("[TB] FAIL latency_done_c%0d: got %b want %b", c, bus.done, (c == NIB + 1));
         end
      end
      exp = expected_q.pop_front();
      n_checks++;
      if (bus.sum !== exp.sum) begin
         n_fail++;
         $display("[TB] FAIL zero_sum: got %h want %h", bus.sum, exp.sum);
      end
      n_checks++;
      if (bus.cout !== exp.cout) begin
         n_fail++;
         $display("[TB] FAIL zero_cout: got %b want %b", bus.cout, exp.cout);
      end
   endtask

   task automatic test_single_op(input string            name,
                                 input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input logic             cin);
      result_t exp;
      int      cyc;
      bit      seen;
      @(negedge clk);
      drive_start(a, b, cin);
      seen = 1'b0;
      cyc  = 0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            cyc  = c;
         end
      end
      exp = expected_q.pop_front();
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("[TB] FAIL %s_timeout: no done within 20 cycles, want done at cycle %0d", name, NIB + 1);
      end else begin
         n_checks++;
         if (cyc != NIB + 1) begin
            n_fail++;
            $display("[TB] FAIL %s_latency: got done at cycle %0d want %0d", name, cyc, NIB + 1);
         end
         n_checks++;
         if (bus.sum !== exp.sum) begin
            n_fail++;
            $display("[TB] FAIL %s_sum: got %h want %h", name, bus.sum, exp.sum);
         end
         n_checks++;
         if (bus.cout !== exp.cout) begin
            n_fail++;
            $display("[TB] FAIL %s_cout: got %b want %b", name, bus.cout, exp.cout);
         end
      end
   endtask

   // Reset two cycles into RUN must kill the operation and clear results.
   task automatic test_reset_abort();
      @(negedge clk);
      bus.a     = 16'h1234;
      bus.b     = 16'h1111;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL abort_busy: got %b want 0", bus.busy);
      end
      n_checks++;
      if (bus.sum !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL abort_sum: got %h want 0000", bus.sum);
      end
      n_checks++;
      if (bus.cout !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL abort_cout: got %b want 0", bus.cout);
      end
      for (int c = 4; c < 12; c++) begin
         @(negedge clk);
         n_checks++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_quiet_c%0d: got done=%b busy=%b want done=0 busy=0", c, bus.done, bus.busy);
         end
      end
   endtask

   // A start while busy must not disturb the operation in flight.
   task automatic test_ignore_start();
      result_t exp;
      @(negedge clk);
      drive_start(16'h0F0F, 16'h00F1, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.a     = 16'hAAAA;
      bus.b     = 16'h5555;
      bus.cin   = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL ignore_busy_c3: got %b want 1", bus.busy);
      end
      @(negedge clk);
      @(negedge clk);
      exp = expected_q.pop_front();
      n_checks++;
      if (bus.done !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL ignore_done_c5: got %b want 1", bus.done);
      end
      n_checks++;
      if (bus.sum !== exp.sum || bus.cout !== exp.cout) begin
         n_fail++;
         $display("[TB] FAIL ignore_result: got sum=%h cout=%b want sum=%h cout=%b", bus.sum, bus.cout, exp.sum, exp.cout);
      end
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL ignore_no_second_op: got done=%b busy=%b want 0 0", bus.done, bus.busy);
      end
   endtask

   // start held in the done cycle launches the next operation immediately.
   task automatic test_back_to_back();
      result_t exp;
      result_t first;
      @(negedge clk);
      drive_start(16'h0001, 16'h0002, 1'b0);
      for (int c = 1; c <= NIB + 1; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      first = expected_q.pop_front();
      n_checks++;
      if (bus.done !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL b2b_first_done: got %b want 1", bus.done);
      end
      n_checks++;
      if (bus.sum !== first.sum || bus.cout !== first.cout) begin
         n_fail++;
         $display("[TB] FAIL b2b_first_result: got sum=%h cout=%b want sum=%h cout=%b", bus.sum, bus.cout, first.sum, first.cout);
      end
      drive_start(16'h8000, 16'h8000, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL b2b_busy_no_idle: got %b want 1", bus.busy);
      end
      n_checks++;
      if (bus.sum !== first.sum || bus.cout !== first.cout) begin
         n_fail++;
         $display("[TB] FAIL b2b_result_hold: got sum=%h cout=%b want sum=%h cout=%b", bus.sum, bus.cout, first.sum, first.cout);
      end
      for (int c = 2; c <= NIB + 1; c++) begin
         @(negedge clk);
         n_checks++;
         if (bus.done !== ((c == NIB + 1) ? 1'b1 : 1'b0)) begin
            n_fail++;
            $display("[TB] FAIL b2b_done_c%0d: got %b want %b", c, bus.done, (c == NIB + 1));
         end
      end
      exp = expected_q.pop_front();
      n_checks++;
      if (bus.sum !== exp.sum || bus.cout !== exp.cout) begin
         n_fail++;
         $display("[TB] FAIL b2b_second_result: got sum=%h cout=%b want sum=%h cout=%b", bus.sum, bus.cout, exp.sum, exp.cout);
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rc;
      for (int i = 0; i < 6; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         rc = 1'($urandom_range(1, 0));
         test_single_op($sformatf("random%0d", i), ra, rb, rc);
      end
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;

      test_reset();
      test_latency_zero();
      test_single_op("ripple", 16'hFFFF, 16'h0001, 1'b0);
      test_reset_abort();
      test_single_op("cin", 16'h1234, 16'h4321, 1'b1);
      test_ignore_start();
      test_back_to_back();
      test_random();

      n_checks++;
      if (expected_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", expected_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
